// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: FSM encoding, MEM/WB bundle, widths.
// Imported by mem_stage and mem_wb_reg.
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_W-1:0]  write_reg;
  } mem_wb_t;

  localparam mem_wb_t BUBBLE = '0;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with enable and bubble insert.
// Resets to all zeros.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    en_i,
  input  logic    bubble_i,
  input  mem_wb_t d_i,
  output mem_wb_t q_o
);

  mem_wb_t wb_q;
  mem_wb_t wb_d;

  always_comb begin
    wb_d = wb_q;
    if (en_i) wb_d = bubble_i ? BUBBLE : d_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wb_q <= BUBBLE;
    else       wb_q <= wb_d;
  end

  assign q_o = wb_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: turns lw/sw into a req/ack data-memory transaction,
// stalls upstream while outstanding, and feeds the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter logic [31:0] POISON      = 32'hDEAD_BEEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              MemRd_i,
  input  logic              MemWr_i,
  input  logic              MemtoReg_i,
  input  logic              RegWrite_i,
  input  logic [DATA_W-1:0] ALUResult_i,
  input  logic [DATA_W-1:0] MemData_i,
  input  logic [REG_W-1:0]  WriteReg_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [DATA_W-1:0] ReadData_o,
  output logic [DATA_W-1:0] ALUResult_o,
  output logic [REG_W-1:0]  WriteReg_o,
  output logic              misalign_o,
  output logic              err_o
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(ACK_TIMEOUT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              mis_q, mis_d;

  logic    memop;
  logic    aligned;
  logic    wb_bubble;
  mem_wb_t wb_in;
  mem_wb_t wb_out;

  assign memop   = MemRd_i | MemWr_i;
  assign aligned = (ALUResult_i[1:0] == 2'b00);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mis_d     = 1'b0;
    wb_bubble = 1'b1;
    wb_in     = '{reg_write:  RegWrite_i,
                  mem_to_reg: MemtoReg_i,
                  read_data:  '0,
                  alu_result: ALUResult_i,
                  write_reg:  WriteReg_i};
    unique case (state_q)
      IDLE: begin
        if (!memop) begin
          wb_bubble = 1'b0;
        end else if (aligned) begin
          state_d = WAIT;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = MemWr_i;
          addr_d  = {ALUResult_i[DATA_W-1:2], 2'b00};
          wdata_d = MemData_i;
        end else begin
          mis_d = 1'b1;
        end
      end
      WAIT: begin
        if (mem_ack_i) begin
          req_d   = 1'b0;
          rdata_d = we_q ? '0 : mem_rdata_i;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (ACK_TIMEOUT != 0 && cnt_d == TO_CNT) begin
            req_d   = 1'b0;
            rdata_d = we_q ? '0 : POISON;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        wb_bubble       = 1'b0;
        wb_in.read_data = rdata_q;
        state_d         = IDLE;
        cnt_d           = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else if (start_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  // Gated by reset so the stall clears with everything else
  always_comb begin
    stall_o = 1'b0;
    unique case (state_q)
      IDLE:    stall_o = memop & aligned;
      WAIT:    stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
    if (rst_i) stall_o = 1'b0;
  end

  mem_wb_reg u_mem_wb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (start_i),
    .bubble_i (wb_bubble),
    .d_i      (wb_in),
    .q_o      (wb_out)
  );

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign misalign_o  = mis_q;
  assign err_o       = err_q;
  assign RegWrite_o  = wb_out.reg_write;
  assign MemtoReg_o  = wb_out.mem_to_reg;
  assign ReadData_o  = wb_out.read_data;
  assign ALUResult_o = wb_out.alu_result;
  assign WriteReg_o  = wb_out.write_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a short ack timeout.
// Each scenario task drives vectors and checks inline.
module tb_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        MemRd_i, MemWr_i, MemtoReg_i, RegWrite_i;
  logic [31:0] ALUResult_i, MemData_i;
  logic [4:0]  WriteReg_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o, RegWrite_o, MemtoReg_o;
  logic [31:0] ReadData_o, ALUResult_o;
  logic [4:0]  WriteReg_o;
  logic        misalign_o, err_o;

  int vecs = 0;
  int errs = 0;
  int stall_cnt;

  mem_stage #(.ACK_TIMEOUT(4), .POISON(32'hDEAD_BEEF)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .MemRd_i(MemRd_i), .MemWr_i(MemWr_i),
    .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i),
    .ALUResult_i(ALUResult_i), .MemData_i(MemData_i),
    .WriteReg_i(WriteReg_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .RegWrite_o(RegWrite_o),
    .MemtoReg_o(MemtoReg_o), .ReadData_o(ReadData_o),
    .ALUResult_o(ALUResult_o), .WriteReg_o(WriteReg_o),
    .misalign_o(misalign_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_in(input logic rd, input logic wr,
                        input logic mtr, input logic rw,
                        input logic [31:0] alu,
                        input logic [31:0] wd,
                        input logic [4:0] wr_reg);
    MemRd_i     = rd;
    MemWr_i     = wr;
    MemtoReg_i  = mtr;
    RegWrite_i  = rw;
    ALUResult_i = alu;
    MemData_i   = wd;
    WriteReg_i  = wr_reg;
  endtask

  task automatic set_nop();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    start_i = 1'b1;
    mem_ack_i = 1'b0;
    mem_rdata_i = 32'h0;
    set_nop();
    #2;
    vecs++;
    if ({mem_req_o, mem_we_o, stall_o, RegWrite_o, MemtoReg_o,
         misalign_o, err_o} !== 7'b0) begin
      errs++;
      $display("FAIL reset_ctrl: got %b want 0",
        {mem_req_o, mem_we_o, stall_o, RegWrite_o, MemtoReg_o,
         misalign_o, err_o});
    end
    vecs++;
    if ({mem_addr_o, mem_wdata_o, ReadData_o, ALUResult_o,
         WriteReg_o} !== '0) begin
      errs++;
      $display("FAIL reset_data: got %h %h %h %h %h want 0",
        mem_addr_o, mem_wdata_o, ReadData_o, ALUResult_o, WriteReg_o);
    end
    #10;
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 5'd8);
    #1;
    vecs++;
    if (stall_o !== 1'b0) begin
      errs++; $display("FAIL alu_stall: got %b want 0", stall_o);
    end
    tick();
    vecs++;
    if ({RegWrite_o, ALUResult_o, WriteReg_o, ReadData_o}
        !== {1'b1, 32'h10, 5'd8, 32'h0}) begin
      errs++;
      $display("FAIL alu_wb: got rw=%b alu=%h rd=%0d data=%h want 1 10 8 0",
        RegWrite_o, ALUResult_o, WriteReg_o, ReadData_o);
    end
    vecs++;
    if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
      errs++;
      $display("FAIL alu_nostall: got stall=%b req=%b want 0 0",
        stall_o, mem_req_o);
    end
    set_nop();
    tick();
  endtask

  task automatic test_lw();
    stall_cnt = 0;
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0, 5'd3);
    #1;
    if (stall_o === 1'b1) stall_cnt++;
    for (int w = 1; w <= 3; w++) begin
      tick();
      if (w == 3) begin
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'h1234_5678;
      end
      if (stall_o === 1'b1) stall_cnt++;
      vecs++;
      if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, 32'h40}) begin
        errs++;
        $display("FAIL lw_req_w%0d: got req=%b we=%b addr=%h want 1 0 40",
          w, mem_req_o, mem_we_o, mem_addr_o);
      end
      vecs++;
      if (RegWrite_o !== 1'b0) begin
        errs++; $display("FAIL lw_bubble_w%0d: got %b want 0", w, RegWrite_o);
      end
    end
    tick();
    mem_ack_i = 1'b0;
    mem_rdata_i = 32'h0;
    if (stall_o === 1'b1) stall_cnt++;
    vecs++;
    if (mem_req_o !== 1'b0 || RegWrite_o !== 1'b0) begin
      errs++;
      $display("FAIL lw_done: got req=%b rw=%b want 0 0",
        mem_req_o, RegWrite_o);
    end
    tick();
    set_nop();
    vecs++;
    if (stall_cnt !== 4) begin
      errs++; $display("FAIL lw_stall_cycles: got %0d want 4", stall_cnt);
    end
    vecs++;
    if ({ReadData_o, MemtoReg_o, RegWrite_o, WriteReg_o, ALUResult_o}
        !== {32'h1234_5678, 1'b1, 1'b1, 5'd3, 32'h40}) begin
      errs++;
      $display("FAIL lw_wb: got data=%h mtr=%b rw=%b rd=%0d alu=%h",
        ReadData_o, MemtoReg_o, RegWrite_o, WriteReg_o, ALUResult_o);
    end
    tick();
  endtask

  task automatic test_sw();
    stall_cnt = 0;
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'hCAFE_F00D, 5'd0);
    #1;
    if (stall_o === 1'b1) stall_cnt++;
    tick();
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h5555_AAAA;
    if (stall_o === 1'b1) stall_cnt++;
    vecs++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}
        !== {1'b1, 1'b1, 32'h8, 32'hCAFE_F00D}) begin
      errs++;
      $display("FAIL sw_req: got req=%b we=%b addr=%h wd=%h",
        mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
    end
    tick();
    mem_ack_i = 1'b0;
    if (stall_o === 1'b1) stall_cnt++;
    vecs++;
    if (mem_req_o !== 1'b0) begin
      errs++; $display("FAIL sw_req_drop: got %b want 0", mem_req_o);
    end
    tick();
    set_nop();
    vecs++;
    if (stall_cnt !== 2) begin
      errs++; $display("FAIL sw_stall_cycles: got %0d want 2", stall_cnt);
    end
    vecs++;
    if (RegWrite_o !== 1'b0 || ReadData_o !== 32'h0) begin
      errs++;
      $display("FAIL sw_wb: got rw=%b data=%h want 0 0",
        RegWrite_o, ReadData_o);
    end
    tick();
  endtask

  task automatic test_misalign();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0042, 32'h0, 5'd4);
    #1;
    vecs++;
    if (stall_o !== 1'b0) begin
      errs++; $display("FAIL mis_stall: got %b want 0", stall_o);
    end
    tick();
    set_nop();
    vecs++;
    if ({misalign_o, mem_req_o, RegWrite_o} !== 3'b100) begin
      errs++;
      $display("FAIL mis_pulse: got mis=%b req=%b rw=%b want 1 0 0",
        misalign_o, mem_req_o, RegWrite_o);
    end
    tick();
    vecs++;
    if (misalign_o !== 1'b0) begin
      errs++; $display("FAIL mis_one_cycle: got %b want 0", misalign_o);
    end
  endtask

  task automatic test_ack_idle();
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h7777_7777;
    tick();
    tick();
    vecs++;
    if ({mem_req_o, stall_o, ReadData_o} !== {1'b0, 1'b0, 32'h0}) begin
      errs++;
      $display("FAIL ack_idle: got req=%b stall=%b data=%h want 0 0 0",
        mem_req_o, stall_o, ReadData_o);
    end
    mem_ack_i = 1'b0;
    mem_rdata_i = 32'h0;
  endtask

  task automatic test_timeout();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0080, 32'h0, 5'd5);
    tick();
    tick();
    tick();
    start_i = 1'b0;
    for (int h = 0; h < 3; h++) tick();
    vecs++;
    if ({mem_req_o, stall_o, err_o} !== 3'b110) begin
      errs++;
      $display("FAIL to_hold: got req=%b stall=%b err=%b want 1 1 0",
        mem_req_o, stall_o, err_o);
    end
    start_i = 1'b1;
    tick();
    vecs++;
    if (mem_req_o !== 1'b1) begin
      errs++; $display("FAIL to_early: got req=%b want 1", mem_req_o);
    end
    tick();
    vecs++;
    if ({mem_req_o, err_o, stall_o} !== 3'b010) begin
      errs++;
      $display("FAIL to_abort: got req=%b err=%b stall=%b want 0 1 0",
        mem_req_o, err_o, stall_o);
    end
    tick();
    set_nop();
    vecs++;
    if ({ReadData_o, RegWrite_o} !== {32'hDEAD_BEEF, 1'b1}) begin
      errs++;
      $display("FAIL to_poison: got data=%h rw=%b want deadbeef 1",
        ReadData_o, RegWrite_o);
    end
    tick();
    tick();
    vecs++;
    if (err_o !== 1'b1) begin
      errs++; $display("FAIL to_sticky: got %b want 1", err_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 5'd6);
    tick();
    vecs++;
    if (mem_req_o !== 1'b1) begin
      errs++; $display("FAIL rst_pre: got req=%b want 1", mem_req_o);
    end
    #2;
    rst_i = 1'b1;
    #1;
    vecs++;
    if ({mem_req_o, stall_o, err_o, RegWrite_o, mem_addr_o}
        !== {4'b0000, 32'h0}) begin
      errs++;
      $display("FAIL rst_async: got req=%b stall=%b err=%b rw=%b addr=%h",
        mem_req_o, stall_o, err_o, RegWrite_o, mem_addr_o);
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0024, 32'h0, 5'd9);
    #3;
    rst_i = 1'b0;
    tick();
    vecs++;
    if ({RegWrite_o, ALUResult_o, WriteReg_o, stall_o}
        !== {1'b1, 32'h24, 5'd9, 1'b0}) begin
      errs++;
      $display("FAIL rst_idle: got rw=%b alu=%h rd=%0d stall=%b",
        RegWrite_o, ALUResult_o, WriteReg_o, stall_o);
    end
    set_nop();
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lw();
    test_sw();
    test_misalign();
    test_ack_idle();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
